// File: rtl/point_controller_if.sv
// Bundle of the rally sequencer's ball-position inputs, game control and
// score/status outputs. The controller uses the master view, the surrounding logic the slave view.
interface point_controller_if;
    logic       frame_tick;
    logic       start;
    logic [9:0] ball_x;
    logic [5:0] ball_width;
    logic       ball_reset;
    logic       ball_enable;
    logic       serve_dir;
    logic       point_left;
    logic       point_right;
    logic [4:0] points_left;
    logic [4:0] points_right;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    modport master (
        input  frame_tick, start, ball_x, ball_width,
        output ball_reset, ball_enable, serve_dir, point_left, point_right,
               points_left, points_right, game_over, winner, state
    );

    modport slave (
        output frame_tick, start, ball_x, ball_width,
        input  ball_reset, ball_enable, serve_dir, point_left, point_right,
               points_left, points_right, game_over, winner, state
    );
endinterface

// File: rtl/point_controller.sv
// Pong rally sequencer: detects edge misses, strobes the score counters,
// waits a frame delay before re-serving and stops the game at the target score.
module point_controller #(
    parameter int RIGHT_EDGE  = 638,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 11
) (
    input  logic               clk,
    input  logic               reset,
    point_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] delay_cnt;
    logic [4:0] points_left_q;
    logic [4:0] points_right_q;
    logic       point_left_q;
    logic       point_right_q;
    logic       serve_dir_q;
    logic       winner_q;

    logic [10:0] ball_right;
    logic        right_miss;
    logic        left_miss;
    logic [4:0]  left_inc;
    logic [4:0]  right_inc;

    // 11-bit sum so ball_x + ball_width can never wrap past the edge test.
    assign ball_right = {1'b0, bus.ball_x} + {5'd0, bus.ball_width};
    assign right_miss = (ball_right >= 11'(RIGHT_EDGE));
    assign left_miss  = (bus.ball_x == 10'd0);
    assign left_inc   = points_left_q + 5'd1;
    assign right_inc  = points_right_q + 5'd1;

    // Scoring leaves PLAY on the same edge, so a ball parked at an edge is counted once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            delay_cnt      <= 8'd0;
            points_left_q  <= 5'd0;
            points_right_q <= 5'd0;
            point_left_q   <= 1'b0;
            point_right_q  <= 1'b0;
            serve_dir_q    <= 1'b1;
            winner_q       <= 1'b0;
        end else begin
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        points_left_q  <= 5'd0;
                        points_right_q <= 5'd0;
                        state_q        <= SERVE;
                    end
                end
                SERVE: begin
                    state_q <= PLAY;
                end
                PLAY: begin
                    if (right_miss) begin
                        point_left_q  <= 1'b1;
                        points_left_q <= left_inc;
                        serve_dir_q   <= 1'b1;
                        delay_cnt     <= 8'd0;
                        if (left_inc == 5'(WIN_SCORE)) begin
                            winner_q <= 1'b0;
                            state_q  <= GAME_OVER;
                        end else begin
                            state_q  <= SCORED;
                        end
                    end else if (left_miss) begin
                        point_right_q  <= 1'b1;
                        points_right_q <= right_inc;
                        serve_dir_q    <= 1'b0;
                        delay_cnt      <= 8'd0;
                        if (right_inc == 5'(WIN_SCORE)) begin
                            winner_q <= 1'b1;
                            state_q  <= GAME_OVER;
                        end else begin
                            state_q  <= SCORED;
                        end
                    end
                end
                SCORED: begin
                    if (bus.frame_tick) begin
                        if (delay_cnt + 8'd1 == 8'(SERVE_DELAY)) begin
                            delay_cnt <= 8'd0;
                            state_q   <= SERVE;
                        end else begin
                            delay_cnt <= delay_cnt + 8'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (bus.start) begin
                        points_left_q  <= 5'd0;
                        points_right_q <= 5'd0;
                        state_q        <= SERVE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ball_reset   = (state_q != PLAY);
    assign bus.ball_enable  = (state_q == PLAY);
    assign bus.game_over    = (state_q == GAME_OVER);
    assign bus.state        = state_q;
    assign bus.serve_dir    = serve_dir_q;
    assign bus.point_left   = point_left_q;
    assign bus.point_right  = point_right_q;
    assign bus.points_left  = points_left_q;
    assign bus.points_right = points_right_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_point_controller.sv
// Scoreboard bench for point_controller: expected point events are queued when a miss
// is staged and checked against each strobe the DUT emits.
module tb_point_controller;

    localparam int RIGHT_EDGE  = 50;
    localparam int SERVE_DELAY = 60;
    localparam int WIN_SCORE   = 11;

    typedef struct {
        logic       left;
        logic [4:0] pl;
        logic [4:0] pr;
        logic       dir;
        logic [2:0] st;
    } exp_t;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;
    int   strobe_count;
    int   model_pl;
    int   model_pr;
    int   model_dir;
    exp_t exp_q[$];

    point_controller_if pc_if();

    point_controller #(
        .RIGHT_EDGE (RIGHT_EDGE),
        .SERVE_DELAY(SERVE_DELAY),
        .WIN_SCORE  (WIN_SCORE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (pc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [5:0] w);
        pc_if.ball_x     = x;
        pc_if.ball_width = w;
    endtask

    // Strobes are sampled on the falling edge; each one must match the oldest queued point.
    always @(negedge clk) begin
        if (!reset && (pc_if.point_left || pc_if.point_right)) begin
            strobe_count++;
            if (exp_q.size() == 0) begin
                checkOutput("pending_points", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_point_left", pc_if.point_left, e.left);
                checkOutput("sb_point_right", pc_if.point_right, !e.left);
                checkOutput("sb_points_left", pc_if.points_left, e.pl);
                checkOutput("sb_points_right", pc_if.points_right, e.pr);
                checkOutput("sb_serve_dir", pc_if.serve_dir, e.dir);
                checkOutput("sb_state", pc_if.state, e.st);
            end
        end
    end

    task automatic runDelay();
        repeat (SERVE_DELAY) begin
            pc_if.frame_tick = 1'b1;
            tick(1);
            pc_if.frame_tick = 1'b0;
            tick(1);
        end
        checkOutput("replay_state", pc_if.state, 2);
    endtask

    // Stages one miss with the ball at (x, w); scorer_left names who gets the point.
    task automatic scorePoint(input bit scorer_left, input logic [9:0] x, input logic [5:0] w);
        exp_t e;
        if (scorer_left) begin
            model_pl++;
            model_dir = 1;
        end else begin
            model_pr++;
            model_dir = 0;
        end
        e.left = scorer_left;
        e.pl   = 5'(model_pl);
        e.pr   = 5'(model_pr);
        e.dir  = 1'(model_dir);
        e.st   = (model_pl == WIN_SCORE || model_pr == WIN_SCORE) ? 3'd4 : 3'd3;
        exp_q.push_back(e);
        applyStimulus(x, w);
        tick(1);
        applyStimulus(10'd20, 6'd8);
        if (e.st == 3'd3) runDelay();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        strobe_count = 0;
        model_pl     = 0;
        model_pr     = 0;
        model_dir    = 1;
        reset            = 1'b1;
        pc_if.frame_tick = 1'b0;
        pc_if.start      = 1'b0;
        applyStimulus(10'd20, 6'd8);
        tick(2);
        reset = 1'b0;
        tick(1);

        checkOutput("reset_state", pc_if.state, 0);
        checkOutput("reset_points_left", pc_if.points_left, 0);
        checkOutput("reset_points_right", pc_if.points_right, 0);
        checkOutput("reset_serve_dir", pc_if.serve_dir, 1);
        checkOutput("reset_ball_reset", pc_if.ball_reset, 1);
        checkOutput("reset_ball_enable", pc_if.ball_enable, 0);
        checkOutput("reset_game_over", pc_if.game_over, 0);

        pc_if.start = 1'b1;
        tick(1);
        checkOutput("serve_state", pc_if.state, 1);
        pc_if.frame_tick = 1'b1;
        tick(1);
        checkOutput("play_state", pc_if.state, 2);
        checkOutput("play_ball_enable", pc_if.ball_enable, 1);
        checkOutput("play_ball_reset", pc_if.ball_reset, 0);
        tick(5);
        checkOutput("play_ignores_start", pc_if.state, 2);
        pc_if.start      = 1'b0;
        pc_if.frame_tick = 1'b0;

        // First rally: ball parked at the right edge must score only once.
        model_pl++;
        exp_q.push_back('{left: 1'b1, pl: 5'd1, pr: 5'd0, dir: 1'b1, st: 3'd3});
        applyStimulus(10'd600, 6'd40);
        tick(1);
        checkOutput("miss_state", pc_if.state, 3);
        checkOutput("miss_points_left", pc_if.points_left, 1);
        tick(100);
        checkOutput("hold_strobe_count", strobe_count, 1);
        applyStimulus(10'd20, 6'd8);
        pc_if.start = 1'b1;
        tick(3);
        checkOutput("scored_ignores_start", pc_if.state, 3);
        pc_if.start = 1'b0;

        repeat (SERVE_DELAY - 1) begin
            pc_if.frame_tick = 1'b1;
            tick(1);
            pc_if.frame_tick = 1'b0;
            tick(1);
        end
        checkOutput("delay_59_state", pc_if.state, 3);
        pc_if.frame_tick = 1'b1;
        tick(1);
        pc_if.frame_tick = 1'b0;
        checkOutput("delay_60_state", pc_if.state, 1);
        tick(1);
        checkOutput("delay_play_state", pc_if.state, 2);

        // x + w = 49 stays in play, 50 is a right-side miss.
        applyStimulus(10'd10, 6'd39);
        tick(3);
        checkOutput("edge_minus_one_state", pc_if.state, 2);
        scorePoint(1'b1, 10'd10, 6'd40);

        // Ball at x=0 also overlapping the right edge: right-side miss wins.
        scorePoint(1'b1, 10'd0, 6'd63);
        checkOutput("both_miss_points_right", pc_if.points_right, 0);

        repeat (WIN_SCORE) scorePoint(1'b0, 10'd0, 6'd8);
        checkOutput("win_state", pc_if.state, 4);
        checkOutput("win_game_over", pc_if.game_over, 1);
        checkOutput("win_winner", pc_if.winner, 1);
        checkOutput("win_ball_enable", pc_if.ball_enable, 0);
        pc_if.frame_tick = 1'b1;
        tick(4);
        pc_if.frame_tick = 1'b0;
        checkOutput("over_hold_points_right", pc_if.points_right, 11);
        checkOutput("over_hold_points_left", pc_if.points_left, 3);

        pc_if.start = 1'b1;
        tick(1);
        pc_if.start = 1'b0;
        checkOutput("restart_state", pc_if.state, 1);
        checkOutput("restart_points_left", pc_if.points_left, 0);
        checkOutput("restart_points_right", pc_if.points_right, 0);
        checkOutput("restart_serve_dir", pc_if.serve_dir, 0);
        tick(1);
        model_pl = 0;
        model_pr = 0;

        repeat (3) scorePoint(1'b1, 10'd600, 6'd40);
        repeat (5) scorePoint(1'b0, 10'd0, 6'd8);
        checkOutput("pre_reset_points_left", pc_if.points_left, 3);
        checkOutput("pre_reset_points_right", pc_if.points_right, 5);

        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_state", pc_if.state, 0);
        checkOutput("async_reset_points_left", pc_if.points_left, 0);
        checkOutput("async_reset_points_right", pc_if.points_right, 0);
        checkOutput("async_reset_ball_reset", pc_if.ball_reset, 1);
        checkOutput("async_reset_serve_dir", pc_if.serve_dir, 1);
        tick(1);
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset_state", pc_if.state, 0);
        checkOutput("post_reset_ball_enable", pc_if.ball_enable, 0);

        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("total_strobes", strobe_count, 1 + 2 + WIN_SCORE + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
